// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU mode encodings, legality helper and scheduler FSM states
package alu_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_ADD = 3'b000;
  localparam mode_t MODE_SUB = 3'b001;
  localparam mode_t MODE_CMP = 3'b010;
  localparam mode_t MODE_AND = 3'b011;
  localparam mode_t MODE_OR  = 3'b100;
  localparam mode_t MODE_XOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 110 and 111 have no ALU meaning; everything up to xor is legal
  function automatic logic mode_legal(input mode_t m);
    return (m <= MODE_XOR);
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - requester-side request/response bundle of the shared ALU scheduler
interface alu_sched_if #(
  parameter int NREQ = 2,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_mode;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [W-1:0]      resp_result;
  logic              resp_zero;
  logic              resp_carry;
  logic              resp_err;

  // requesters drive requests and accept responses
  modport master (
    output req_valid, req_a, req_b, req_mode, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_carry, resp_err
  );

  // the scheduler accepts requests and drives responses
  modport slave (
    input  req_valid, req_a, req_b, req_mode, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_carry, resp_err
  );
endinterface

// File: rtl/alu_sched_arb.sv
// rtl/alu_sched_arb.sv - one-hot grant picker; ALU_SCHED_RR_EN selects round-robin, else fixed priority
module alu_sched_arb #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

`ifdef ALU_SCHED_RR_EN
  // first requester found searching upward from ptr, wrapping at NREQ
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // lowest requesting index wins
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - shares one combinational ALU among NREQ requesters, one op in flight; ALU_SCHED_RR_EN enables round-robin
module alu_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_sched_if.slave   bus,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output mode_t        alu_mode,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_carry
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  state_t            state;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ready;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   resp_valid_q;
  logic              accept;
  logic [W-1:0]      sel_a;
  logic [W-1:0]      sel_b;
  mode_t             sel_mode;
  logic [W-1:0]      res_q;
  logic              zero_q;
  logic              carry_q;
  logic              err_q;
  logic [PW-1:0]     rr_ptr;

  alu_sched_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign ready  = (state == ST_IDLE && !reset) ? grant : '0;
  assign accept = |(bus.req_valid & ready);

`ifdef ALU_SCHED_RR_EN
  logic [PW-1:0] g_idx;

  // binary index of the current winner
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) g_idx = PW'(i);
  end

  // next search starts one past the requester just accepted
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
  end
`else
  assign rr_ptr = '0;
`endif

  // route the winner's operands and mode toward the operand registers
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_mode = MODE_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = bus.req_a[i*W +: W];
        sel_b    = bus.req_b[i*W +: W];
        sel_mode = bus.req_mode[i*3 +: 3];
      end
    end
  end

  // scheduler FSM: ALU inputs are live only in EXEC, responses held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_mode     <= MODE_ADD;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_in1  <= sel_a;
            alu_in2  <= sel_b;
            alu_mode <= sel_mode;
            gnt_q    <= grant;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          err_q <= 1'b0;
          if (!mode_legal(alu_mode)) begin
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b1;
          end else if (alu_mode == MODE_CMP) begin
            res_q   <= '0;
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
          end else if (alu_mode == MODE_ADD || alu_mode == MODE_SUB) begin
            res_q   <= alu_out;
            zero_q  <= (alu_out == '0);
            carry_q <= alu_carry;
          end else begin
            res_q   <= alu_out;
            zero_q  <= (alu_out == '0);
            carry_q <= 1'b0;
          end
          alu_in1      <= '0;
          alu_in2      <= '0;
          alu_mode     <= MODE_ADD;
          resp_valid_q <= gnt_q;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (|(resp_valid_q & bus.resp_ready)) begin
            resp_valid_q <= '0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = res_q;
  assign bus.resp_zero   = zero_q;
  assign bus.resp_carry  = carry_q;
  assign bus.resp_err    = err_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched with NREQ=2, W=8
module tb_alu_sched;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  mode_t        alu_mode;
  logic         alu_zero, alu_carry;
  logic [W:0]   alu_wide;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_mode  (alu_mode),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry)
  );

  // reference ALU; illegal modes return junk with both flags set
  always_comb begin
    alu_wide = '0;
    case (alu_mode)
      3'b000:         alu_wide = {1'b0, alu_in1} + {1'b0, alu_in2};
      3'b001, 3'b010: alu_wide = {1'b0, alu_in1} - {1'b0, alu_in2};
      3'b011:         alu_wide = {1'b0, alu_in1 & alu_in2};
      3'b100:         alu_wide = {1'b0, alu_in1 | alu_in2};
      3'b101:         alu_wide = {1'b0, alu_in1 ^ alu_in2};
      default:        alu_wide = 9'h1AA;
    endcase
  end
  assign alu_out   = alu_wide[W-1:0];
  assign alu_carry = alu_wide[W];
  assign alu_zero  = mode_legal(alu_mode) ? (alu_out == '0) : 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] mode, input logic [7:0] er, input logic ez,
                       input logic ec, input logic ee);
    logic [1:0] oh;
    oh = 2'(1 << idx);
    @(negedge clk);
    bus.req_valid = oh;
    bus.req_a     = {a, a};
    bus.req_b     = {b, b};
    bus.req_mode  = {mode, mode};
    #1;
    check({tag, ".accept_ready"}, 32'(bus.req_ready), 32'(oh));
    @(negedge clk);
    bus.req_valid = '0;
    check({tag, ".exec_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, ".exec_rv"}, 32'(bus.resp_valid), 32'h0);
    check({tag, ".exec_in1"}, 32'(alu_in1), 32'(a));
    check({tag, ".exec_in2"}, 32'(alu_in2), 32'(b));
    check({tag, ".exec_mode"}, 32'(alu_mode), 32'(mode));
    @(negedge clk);
    check({tag, ".rv"}, 32'(bus.resp_valid), 32'(oh));
    check({tag, ".result"}, 32'(bus.resp_result), 32'(er));
    check({tag, ".zero"}, 32'(bus.resp_zero), 32'(ez));
    check({tag, ".carry"}, 32'(bus.resp_carry), 32'(ec));
    check({tag, ".err"}, 32'(bus.resp_err), 32'(ee));
    check({tag, ".resp_in1"}, 32'(alu_in1), 32'h0);
    bus.resp_ready = oh;
    @(negedge clk);
    check({tag, ".done_rv"}, 32'(bus.resp_valid), 32'h0);
    check({tag, ".held_result"}, 32'(bus.resp_result), 32'(er));
    bus.resp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_gnt [4];
    logic [1:0] seen;

    reset          = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_mode   = '0;
    bus.resp_ready = '0;

    // reset state, with requests present during reset
    repeat (2) @(negedge clk);
    check("rst.req_ready", 32'(bus.req_ready), 32'h0);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst.result", 32'(bus.resp_result), 32'h0);
    check("rst.flags", 32'({bus.resp_zero, bus.resp_carry, bus.resp_err}), 32'h0);
    check("rst.alu", 32'({alu_in1, alu_in2, alu_mode}), 32'h0);
    bus.req_valid = '0;
    reset = 1'b0;

    // directed operations
    do_op("add",        0, 8'hF0, 8'h20, 3'b000, 8'h10, 1'b0, 1'b1, 1'b0);
    do_op("cmp_lt",     0, 8'h05, 8'h09, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op("cmp_eq",     1, 8'h33, 8'h33, 3'b010, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op("sub_zero",   1, 8'h05, 8'h05, 3'b001, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op("sub_borrow", 0, 8'h03, 8'h05, 3'b001, 8'hFE, 1'b0, 1'b1, 1'b0);
    do_op("and",        1, 8'hF0, 8'h3C, 3'b011, 8'h30, 1'b0, 1'b0, 1'b0);
    do_op("or",         0, 8'h0F, 8'h30, 3'b100, 8'h3F, 1'b0, 1'b0, 1'b0);
    do_op("xor",        1, 8'hFF, 8'hFF, 3'b101, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op("ill111",     0, 8'h12, 8'h34, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1);
    do_op("ill110",     1, 8'h12, 8'h34, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1);

    // response backpressure; req1 waits, its resp_ready bit is ignored
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_a     = {8'h01, 8'h01};
    bus.req_b     = {8'h01, 8'h01};
    bus.req_mode  = '0;
    @(negedge clk);
    bus.req_valid  = 2'b10;
    @(negedge clk);
    bus.resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check("bp.rv", 32'(bus.resp_valid), 32'h1);
      check("bp.result", 32'(bus.resp_result), 32'h02);
      check("bp.ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
    end
    bus.resp_ready = 2'b01;
    @(negedge clk);
    check("bp.release_rv", 32'(bus.resp_valid), 32'h0);
    check("bp.release_idle", 32'(bus.req_ready), 32'h2);
    bus.req_valid  = '0;
    bus.resp_ready = '0;

    // arbitration with both requesters continuously valid
`ifdef ALU_SCHED_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b11;
    for (int g = 0; g < 4; g++) begin
      seen = '0;
      for (int t = 0; t < 6; t++) begin
        @(negedge clk);
        seen = bus.req_ready;
        if (seen != '0) break;
      end
      check($sformatf("arb.grant%0d", g), 32'(seen), 32'(exp_gnt[g]));
    end
    bus.req_valid  = '0;
    bus.resp_ready = '0;

    // reset during EXEC drops the operation
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_a     = {8'h11, 8'h11};
    bus.req_b     = {8'h22, 8'h22};
    bus.req_mode  = '0;
    @(negedge clk);
    bus.req_valid = '0;
    check("rexec.in_exec", 32'(alu_in1), 32'h11);
    reset = 1'b1;
    @(negedge clk);
    check("rexec.rv", 32'(bus.resp_valid), 32'h0);
    check("rexec.result", 32'(bus.resp_result), 32'h0);
    check("rexec.alu", 32'({alu_in1, alu_in2, alu_mode}), 32'h0);
    check("rexec.ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rexec.no_resp", 32'(bus.resp_valid), 32'h0);
    end
    do_op("after_reset", 1, 8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
